// File: rtl/manchester_serdes.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : manchester_serdes
// Purpose  : Serial Manchester transceiver. The TX side serialises a
//            DATA_W-bit word MSB-first onto a one-wire Manchester line. The RX
//            side samples a framed Manchester line, rebuilds the word, flags
//            bad symbols and truncated frames, and keeps a saturating count
//            of errored frames.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            tx_data/tx_valid    - word to send, handshake with tx_ready
//            tx_ready            - TX idle, a word can be accepted
//            tx_line/tx_active   - registered line output and frame envelope
//            rx_line/rx_frame    - line input and its frame envelope
//            rx_data/rx_valid    - received word, one-cycle valid pulse
//            rx_err              - symbol error or truncation (with rx_valid)
//            err_count           - errored frames, saturating
// Revision : 1.0 - initial release
// ============================================================================
module manchester_serdes #(
    parameter int DATA_W     = 8,
    parameter int HALF_CYC   = 4,
    parameter int CONVENTION = 0,
    parameter int ERRCNT_W   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DATA_W-1:0]   tx_data,
    input  logic                tx_valid,
    output logic                tx_ready,
    output logic                tx_line,
    output logic                tx_active,
    input  logic                rx_line,
    input  logic                rx_frame,
    output logic [DATA_W-1:0]   rx_data,
    output logic                rx_valid,
    output logic                rx_err,
    output logic [ERRCNT_W-1:0] err_count
);

    localparam int c_HB_W  = $clog2(2 * DATA_W + 1);
    localparam int c_POS_W = $clog2(HALF_CYC + 1);

    localparam logic [c_HB_W-1:0]  c_LAST_HB  = c_HB_W'(2 * DATA_W - 1);
    localparam logic [c_POS_W-1:0] c_LAST_POS = c_POS_W'(HALF_CYC - 1);
    localparam logic [c_POS_W-1:0] c_MID_POS  = c_POS_W'(HALF_CYC / 2);
    // First half-bit of a '1' is high for Thomas, low for IEEE 802.3.
    localparam logic               c_CONV     = (CONVENTION != 0);

    localparam logic [0:0] c_TX_IDLE = 1'b0;
    localparam logic [0:0] c_TX_SEND = 1'b1;

    localparam logic [1:0] c_RX_IDLE   = 2'd0;
    localparam logic [1:0] c_RX_SAMPLE = 2'd1;
    localparam logic [1:0] c_RX_WAIT   = 2'd2;

    // ------------------------------------------------------------------------
    // TX path
    // ------------------------------------------------------------------------
    logic [0:0]         r_tx_state;
    logic [0:0]         w_tx_state_nxt;
    logic [DATA_W-1:0]  r_tx_shift;
    logic [DATA_W-1:0]  w_tx_shift_nxt;
    logic [c_HB_W-1:0]  r_tx_hb;
    logic [c_POS_W-1:0] r_tx_pos;
    logic               w_tx_accept;
    logic               w_tx_half_end;
    logic               w_tx_last;

    assign w_tx_accept    = tx_valid && tx_ready;
    assign w_tx_half_end  = (r_tx_pos == c_LAST_POS);
    assign w_tx_last      = w_tx_half_end && (r_tx_hb == c_LAST_HB);
    assign w_tx_shift_nxt = r_tx_shift << 1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_state <= c_TX_IDLE;
        end else begin
            r_tx_state <= w_tx_state_nxt;
        end
    end

    always_comb begin
        w_tx_state_nxt = r_tx_state;
        case (r_tx_state)
            c_TX_IDLE: if (w_tx_accept) w_tx_state_nxt = c_TX_SEND;
            c_TX_SEND: if (w_tx_last)   w_tx_state_nxt = c_TX_IDLE;
            default:                    w_tx_state_nxt = c_TX_IDLE;
        endcase
    end

    // The word's current bit always sits in the MSB of r_tx_shift; the shift
    // happens when moving from a second half-bit to the next first half-bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_shift <= '0;
            r_tx_hb    <= '0;
            r_tx_pos   <= '0;
            tx_line    <= 1'b0;
            tx_active  <= 1'b0;
            tx_ready   <= 1'b1;
        end else if (r_tx_state == c_TX_IDLE) begin
            if (w_tx_accept) begin
                r_tx_shift <= tx_data;
                r_tx_hb    <= '0;
                r_tx_pos   <= '0;
                tx_line    <= tx_data[DATA_W-1] ^ c_CONV;
                tx_active  <= 1'b1;
                tx_ready   <= 1'b0;
            end
        end else if (w_tx_half_end) begin
            r_tx_pos <= '0;
            if (w_tx_last) begin
                tx_line   <= 1'b0;
                tx_active <= 1'b0;
                tx_ready  <= 1'b1;
            end else begin
                r_tx_hb <= r_tx_hb + 1'b1;
                if (r_tx_hb[0]) begin
                    r_tx_shift <= w_tx_shift_nxt;
                    tx_line    <= w_tx_shift_nxt[DATA_W-1] ^ c_CONV;
                end else begin
                    // Second half of a symbol is always the complement.
                    tx_line <= ~tx_line;
                end
            end
        end else begin
            r_tx_pos <= r_tx_pos + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // RX path
    // ------------------------------------------------------------------------
    logic [1:0]         r_rx_state;
    logic [1:0]         w_rx_state_nxt;
    logic [c_HB_W-1:0]  r_rx_hb;
    logic [c_POS_W-1:0] r_rx_pos;
    logic               r_rx_first;
    logic               r_rx_flag;
    logic [DATA_W-1:0]  r_rx_word;
    logic [DATA_W-1:0]  w_rx_word_nxt;
    logic               w_rx_sample;
    logic               w_rx_final;
    logic               w_rx_trunc;
    logic               w_sym_err;
    logic               w_rx_bit;
    logic               w_frame_err;
    logic               w_deliver;
    logic [ERRCNT_W-1:0] w_err_cnt_inc;

    assign w_rx_trunc    = (r_rx_state == c_RX_SAMPLE) && !rx_frame;
    assign w_rx_sample   = (r_rx_state == c_RX_SAMPLE) && rx_frame && (r_rx_pos == c_MID_POS);
    assign w_rx_final    = w_rx_sample && (r_rx_hb == c_LAST_HB);
    assign w_sym_err     = (r_rx_first == rx_line);
    assign w_rx_bit      = !w_sym_err && (r_rx_first ^ c_CONV);
    assign w_rx_word_nxt = (r_rx_word << 1) | DATA_W'(w_rx_bit);
    assign w_deliver     = w_rx_final || w_rx_trunc;
    assign w_frame_err   = w_rx_trunc || (w_rx_final && (r_rx_flag || w_sym_err));
    assign w_err_cnt_inc = (err_count == {ERRCNT_W{1'b1}}) ? err_count : err_count + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_state <= c_RX_IDLE;
        end else begin
            r_rx_state <= w_rx_state_nxt;
        end
    end

    always_comb begin
        w_rx_state_nxt = r_rx_state;
        case (r_rx_state)
            c_RX_IDLE: begin
                if (rx_frame) w_rx_state_nxt = c_RX_SAMPLE;
            end
            c_RX_SAMPLE: begin
                if (w_rx_trunc)      w_rx_state_nxt = c_RX_IDLE;
                else if (w_rx_final) w_rx_state_nxt = c_RX_WAIT;
            end
            c_RX_WAIT: begin
                if (!rx_frame) w_rx_state_nxt = c_RX_IDLE;
            end
            default: w_rx_state_nxt = c_RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_hb    <= '0;
            r_rx_pos   <= '0;
            r_rx_first <= 1'b0;
            r_rx_flag  <= 1'b0;
            r_rx_word  <= '0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_err     <= 1'b0;
            err_count  <= '0;
        end else begin
            rx_valid <= 1'b0;
            if (r_rx_state == c_RX_IDLE) begin
                // The cycle that sees rx_frame high is frame cycle 0, so the
                // next cycle is already position 1 of half-bit 0.
                r_rx_hb   <= '0;
                r_rx_pos  <= c_POS_W'(1);
                r_rx_flag <= 1'b0;
                r_rx_word <= '0;
            end else if (r_rx_state == c_RX_SAMPLE) begin
                if (r_rx_pos == c_LAST_POS) begin
                    r_rx_pos <= '0;
                    r_rx_hb  <= r_rx_hb + 1'b1;
                end else begin
                    r_rx_pos <= r_rx_pos + 1'b1;
                end
                if (w_rx_sample) begin
                    if (!r_rx_hb[0]) begin
                        r_rx_first <= rx_line;
                    end else begin
                        r_rx_word <= w_rx_word_nxt;
                        r_rx_flag <= r_rx_flag || w_sym_err;
                    end
                end
            end
            if (w_deliver) begin
                rx_valid <= 1'b1;
                rx_err   <= w_frame_err;
                rx_data  <= w_rx_trunc ? '0 : w_rx_word_nxt;
                if (w_frame_err) err_count <= w_err_cnt_inc;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_manchester_serdes.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module   : tb_manchester_serdes
// Purpose  : Self-checking bench for manchester_serdes. A frame-level model
//            predicts the Thomas-convention instance cycle by cycle; directed
//            scenarios pin exact values for both conventions.
// Revision : 1.0 - initial release
// ============================================================================
module tb_manchester_serdes;

    localparam int DW     = 8;
    localparam int HC     = 4;
    localparam int FL     = 2 * DW * HC;
    localparam int LAST_S = (2 * DW - 1) * HC + HC / 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Thomas instance (model-checked) and IEEE instance (directed checks).
    logic [7:0] tx_data0 = '0, tx_data1 = '0;
    logic       tx_valid0 = 1'b0, tx_valid1 = 1'b0;
    logic       tx_ready0, tx_line0, tx_active0, rx_valid0, rx_err0;
    logic       tx_ready1, tx_line1, tx_active1, rx_valid1, rx_err1;
    logic [7:0] rx_data0, rx_data1, err_count0, err_count1;
    logic       rx_line0, rx_frame0;

    logic lb = 1'b1, force_hi = 1'b0, drop = 1'b0, drv_line = 1'b0, drv_frame = 1'b0;
    assign rx_line0  = lb ? (tx_line0 | force_hi) : drv_line;
    assign rx_frame0 = lb ? (tx_active0 & ~drop) : drv_frame;

    manchester_serdes #(.DATA_W(DW), .HALF_CYC(HC), .CONVENTION(0), .ERRCNT_W(8)) dut0 (
        .clk(clk), .rst(rst), .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready0),
        .tx_line(tx_line0), .tx_active(tx_active0), .rx_line(rx_line0), .rx_frame(rx_frame0),
        .rx_data(rx_data0), .rx_valid(rx_valid0), .rx_err(rx_err0), .err_count(err_count0));

    manchester_serdes #(.DATA_W(DW), .HALF_CYC(HC), .CONVENTION(1), .ERRCNT_W(8)) dut1 (
        .clk(clk), .rst(rst), .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready1),
        .tx_line(tx_line1), .tx_active(tx_active1), .rx_line(tx_line1), .rx_frame(tx_active1),
        .rx_data(rx_data1), .rx_valid(rx_valid1), .rx_err(rx_err1), .err_count(err_count1));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Half-bit h of word w as it appears on the line.
    function automatic logic hb_val(input logic [7:0] w, input int h, input int conv);
        logic b;
        b = w[7 - h / 2];
        if (conv != 0) b = ~b;
        if (h % 2 == 1) b = ~b;
        return b;
    endfunction

    // Decode 16 sampled half-bits into {error, word}.
    function automatic logic [8:0] decode(input logic [15:0] s, input int conv);
        logic [7:0] d;
        logic       e, a, b;
        d = '0;
        e = 1'b0;
        for (int i = 0; i < 8; i++) begin
            a = s[2 * i];
            b = s[2 * i + 1];
            if (a == b) e = 1'b1;
            else d[7 - i] = (conv != 0) ? b : a;
        end
        return {e, d};
    endfunction

    // ------------------------------------------------------------------------
    // Delivered-word logs
    // ------------------------------------------------------------------------
    typedef struct {
        logic [7:0] d;
        logic       e;
        int         c;
    } ev_t;
    ev_t q0[$];
    ev_t q1[$];

    always @(negedge clk) begin
        if (rx_valid0 === 1'b1) q0.push_back('{rx_data0, rx_err0, cyc});
        if (rx_valid1 === 1'b1) q1.push_back('{rx_data1, rx_err1, cyc});
    end

    // ------------------------------------------------------------------------
    // Model of dut0: at each falling edge compare against the prediction made
    // one cycle earlier, then predict the next cycle from the current inputs.
    // ------------------------------------------------------------------------
    logic        m_ok = 1'b0;
    logic        m_tx_busy = 1'b0;
    logic [7:0]  m_tx_word = '0;
    int          m_tx_t = 0;
    int          m_rx_st = 0;
    int          m_f = 0;
    logic [15:0] m_s = '0;
    logic        e_ready = 1'b1, e_active = 1'b0, e_line = 1'b0;
    logic        e_valid = 1'b0, e_err = 1'b0;
    logic [7:0]  e_data = '0, e_cnt = '0;

    always @(negedge clk) begin
        logic [8:0] dec;
        if (m_ok) begin
            chk("m_tx_ready", tx_ready0, e_ready);
            chk("m_tx_active", tx_active0, e_active);
            chk("m_tx_line", tx_line0, e_line);
            chk("m_rx_valid", rx_valid0, e_valid);
            chk("m_rx_data", rx_data0, e_data);
            chk("m_err_count", err_count0, e_cnt);
            if (e_valid) chk("m_rx_err", rx_err0, e_err);
        end
        e_valid = 1'b0;
        if (rst) begin
            m_tx_busy = 1'b0;
            m_rx_st   = 0;
            e_data    = '0;
            e_err     = 1'b0;
            e_cnt     = '0;
            m_ok      = 1'b1;
        end else begin
            if (m_tx_busy) begin
                m_tx_t++;
                if (m_tx_t == FL) m_tx_busy = 1'b0;
            end else if (tx_valid0) begin
                m_tx_busy = 1'b1;
                m_tx_word = tx_data0;
                m_tx_t    = 0;
            end
            case (m_rx_st)
                0: if (rx_frame0) begin
                    m_rx_st = 1;
                    m_f     = 1;
                end
                1: if (!rx_frame0) begin
                    e_valid = 1'b1;
                    e_err   = 1'b1;
                    e_data  = '0;
                    if (e_cnt != 8'hFF) e_cnt++;
                    m_rx_st = 0;
                end else begin
                    if (m_f % HC == HC / 2) m_s[m_f / HC] = rx_line0;
                    if (m_f == LAST_S) begin
                        dec     = decode(m_s, 0);
                        e_valid = 1'b1;
                        e_err   = dec[8];
                        e_data  = dec[7:0];
                        if (dec[8] && e_cnt != 8'hFF) e_cnt++;
                        m_rx_st = 2;
                    end
                    m_f++;
                end
                default: if (!rx_frame0) m_rx_st = 0;
            endcase
        end
        e_ready  = !m_tx_busy;
        e_active = m_tx_busy;
        e_line   = m_tx_busy ? hb_val(m_tx_word, m_tx_t / HC, 0) : 1'b0;
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Returns at frame cycle 0 of the accepted word.
    task automatic send(input int sel, input logic [7:0] w, output int waited);
        waited = 0;
        while (((sel == 0) ? tx_ready0 : tx_ready1) !== 1'b1 && waited < 200) begin
            step();
            waited++;
        end
        chk("send_ready_timeout", 64'(waited >= 200), 64'd0);
        if (sel == 0) begin
            tx_data0  = w;
            tx_valid0 = 1'b1;
        end else begin
            tx_data1  = w;
            tx_valid1 = 1'b1;
        end
        step();
        tx_valid0 = 1'b0;
        tx_valid1 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          w, w2, s0, s1, s2, n_act, n_nrdy, guard;
        logic [63:0] got, exp;
        logic [15:0] pat;

        // Reset state
        rst = 1'b1;
        repeat (3) step();
        chk("rst_tx_ready", tx_ready0, 1);
        chk("rst_tx_line", tx_line0, 0);
        chk("rst_tx_active", tx_active0, 0);
        chk("rst_rx_valid", rx_valid0, 0);
        chk("rst_rx_data", rx_data0, 0);
        chk("rst_rx_err", rx_err0, 0);
        chk("rst_err_count", err_count0, 0);
        chk("rst_tx_ready1", tx_ready1, 1);
        rst = 1'b0;
        step();

        // 0xB2 Thomas, looped back
        lb = 1'b1;
        q0.delete();
        send(0, 8'hB2, w);
        s0 = cyc;
        n_act = 0;
        n_nrdy = 0;
        got = '0;
        for (int t = 0; t < 70; t++) begin
            if (t < 64) got[t] = tx_line0;
            n_act  += int'(tx_active0);
            n_nrdy += int'(!tx_ready0);
            step();
        end
        pat = 16'b1001101001011001;
        for (int t = 0; t < 64; t++) exp[t] = pat[15 - t / 4];
        chk("b2_tx_line_pattern", got, exp);
        chk("b2_tx_active_cycles", n_act, 64);
        chk("b2_tx_ready_low_cycles", n_nrdy, 64);
        chk("b2_rx_valid_count", q0.size(), 1);
        if (q0.size() > 0) begin
            chk("b2_rx_data", q0[0].d, 8'hB2);
            chk("b2_rx_err", q0[0].e, 0);
            chk("b2_rx_valid_cycle", q0[0].c - s0, 63);
        end
        chk("b2_err_count", err_count0, 0);

        // IEEE 0xF0 then back-to-back 0xAA, looped back
        q1.delete();
        send(1, 8'hF0, w);
        s1 = cyc;
        got = '0;
        for (int t = 0; t < 64; t++) begin
            got[t] = tx_line1;
            step();
        end
        send(1, 8'hAA, w2);
        s2 = cyc;
        chk("b2b_accept_wait", w2, 0);
        repeat (75) step();
        pat = 16'b0101010110101010;
        for (int t = 0; t < 64; t++) exp[t] = pat[15 - t / 4];
        chk("f0_tx_line_pattern", got, exp);
        chk("ieee_rx_valid_count", q1.size(), 2);
        if (q1.size() > 1) begin
            chk("f0_rx_data", q1[0].d, 8'hF0);
            chk("f0_rx_err", q1[0].e, 0);
            chk("f0_rx_valid_cycle", q1[0].c - s1, 63);
            chk("aa_rx_data", q1[1].d, 8'hAA);
            chk("aa_rx_err", q1[1].e, 0);
            chk("aa_rx_valid_cycle", q1[1].c - s2, 63);
        end
        chk("ieee_err_count", err_count1, 0);

        // Symbol error: rx_line forced high over half-bits 6 and 7
        q0.delete();
        send(0, 8'hB2, w);
        s0 = cyc;
        repeat (24) step();
        force_hi = 1'b1;
        repeat (8) step();
        force_hi = 1'b0;
        repeat (40) step();
        chk("sym_rx_valid_count", q0.size(), 1);
        if (q0.size() > 0) begin
            chk("sym_rx_data", q0[0].d, 8'hA2);
            chk("sym_rx_err", q0[0].e, 1);
            chk("sym_rx_valid_cycle", q0[0].c - s0, 63);
        end
        chk("sym_err_count", err_count0, 1);

        // Truncation: rx_frame dropped at frame cycle 30
        q0.delete();
        send(0, 8'hB2, w);
        s0 = cyc;
        repeat (30) step();
        drop = 1'b1;
        repeat (3) step();
        guard = 0;
        while (tx_active0 === 1'b1 && guard < 100) begin
            step();
            guard++;
        end
        chk("trunc_tx_end_timeout", 64'(guard >= 100), 64'd0);
        drop = 1'b0;
        step();
        chk("trunc_rx_valid_count", q0.size(), 1);
        if (q0.size() > 0) begin
            chk("trunc_rx_data", q0[0].d, 0);
            chk("trunc_rx_err", q0[0].e, 1);
            chk("trunc_rx_valid_cycle", q0[0].c - s0, 31);
        end
        chk("trunc_err_count", err_count0, 2);

        // Long frame: rx_frame high 80 cycles carrying 0x5C
        lb = 1'b0;
        q0.delete();
        s0 = 0;
        for (int f = 0; f < 80; f++) begin
            drv_frame = 1'b1;
            drv_line  = (f < 64) ? hb_val(8'h5C, f / HC, 0) : 1'($urandom_range(0, 1));
            if (f == 0) s0 = cyc;
            step();
        end
        drv_frame = 1'b0;
        repeat (4) step();
        chk("long_rx_valid_count", q0.size(), 1);
        if (q0.size() > 0) begin
            chk("long_rx_data", q0[0].d, 8'h5C);
            chk("long_rx_err", q0[0].e, 0);
            chk("long_rx_valid_cycle", q0[0].c - s0, 63);
        end

        // Reset at frame cycle 20
        lb = 1'b1;
        q0.delete();
        send(0, 8'hB2, w);
        repeat (20) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_tx_ready", tx_ready0, 1);
        chk("midrst_tx_line", tx_line0, 0);
        chk("midrst_tx_active", tx_active0, 0);
        chk("midrst_rx_valid", rx_valid0, 0);
        chk("midrst_rx_data", rx_data0, 0);
        chk("midrst_rx_err", rx_err0, 0);
        chk("midrst_err_count", err_count0, 0);
        repeat (80) step();
        chk("midrst_no_rx_valid", q0.size(), 0);

        // 300 truncated frames: counter saturates
        lb = 1'b0;
        q0.delete();
        for (int i = 0; i < 300; i++) begin
            drv_frame = 1'b1;
            step();
            drv_frame = 1'b0;
            repeat (3) step();
        end
        repeat (3) step();
        chk("sat_rx_valid_count", q0.size(), 300);
        chk("sat_err_count", err_count0, 8'hFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
